// File: rtl/nor_fetch_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nor_fetch_buffer
// Description : Single-line read buffer between the core instruction bus and
//               the QSPI NOR wrapper. Same-line reads hit in one cycle; a miss
//               refills the whole line with word-sequential downstream reads.
//               A flush pulse invalidates the line after NOR writes.
// Revision    : 1.0 - initial release
// ============================================================================
module nor_fetch_buffer #(
    parameter int LINE_WORDS = 4,
    parameter int XLEN       = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int ACC_W      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [XLEN-1:0]      i_addr,
    input  logic                 i_w_rb,
    input  logic [ACC_W-1:0]     i_acc,
    input  logic [BUS_WIDTH-1:0] i_wdata,
    input  logic                 i_req,
    output logic [BUS_WIDTH-1:0] i_rdata,
    output logic                 i_resp,
    output logic                 i_fault,
    output logic [XLEN-1:0]      nor_addr,
    output logic                 nor_w_rb,
    output logic [ACC_W-1:0]     nor_acc,
    output logic [BUS_WIDTH-1:0] nor_wdata,
    output logic                 nor_req,
    input  logic [BUS_WIDTH-1:0] nor_rdata,
    input  logic                 nor_resp,
    input  logic                 nor_fault
);

    localparam int OFF_W = $clog2(LINE_WORDS * 4);
    localparam int CW    = OFF_W - 2;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_FILL = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [ACC_W-1:0] c_ACC_BYTE = ACC_W'(0);
    localparam logic [ACC_W-1:0] c_ACC_HALF = ACC_W'(1);
    localparam logic [ACC_W-1:0] c_ACC_WORD = ACC_W'(2);
    localparam logic [CW-1:0]    c_LAST     = CW'(LINE_WORDS - 1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic                   r_valid;
    logic                   r_flush_pend;
    logic                   r_fill_fault;
    logic [CW-1:0]          r_cnt;
    logic [XLEN-OFF_W-1:0]  r_tag;
    logic [XLEN-1:0]        r_addr;
    logic [ACC_W-1:0]       r_acc;
    logic [BUS_WIDTH-1:0]   r_line [LINE_WORDS];

    logic                   w_bad;
    logic                   w_hit;
    logic                   w_last;
    logic [CW-1:0]          w_cnt_inc;
    logic                   w_unused_wdata;

    // Pick the addressed byte/half/word out of a buffered word, zero-extended.
    function automatic logic [BUS_WIDTH-1:0] f_extract(
        input logic [BUS_WIDTH-1:0] word,
        input logic [1:0]           off,
        input logic [ACC_W-1:0]     acc
    );
        logic [BUS_WIDTH-1:0] w_sh;
        f_extract = '0;
        w_sh      = '0;
        case (acc)
            c_ACC_BYTE: begin
                w_sh            = word >> {off, 3'b000};
                f_extract[7:0]  = w_sh[7:0];
            end
            c_ACC_HALF: begin
                w_sh            = word >> {off[1], 4'b0000};
                f_extract[15:0] = w_sh[15:0];
            end
            c_ACC_WORD: f_extract = word;
            default:    f_extract = '0;
        endcase
    endfunction

    // Writes are not supported; the write data port only exists for bus symmetry.
    assign w_unused_wdata = ^i_wdata;

    // Writes, misaligned accesses and undefined access sizes fault without touching NOR.
    assign w_bad = i_w_rb
                || (i_acc == c_ACC_HALF && i_addr[0])
                || (i_acc == c_ACC_WORD && i_addr[1:0] != 2'b00)
                || (i_acc > c_ACC_WORD);
    assign w_hit     = r_valid && (i_addr[XLEN-1:OFF_W] == r_tag);
    assign w_last    = (r_cnt == c_LAST);
    assign w_cnt_inc = r_cnt + 1'b1;

    assign nor_w_rb  = 1'b0;
    assign nor_acc   = c_ACC_WORD;
    assign nor_wdata = '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: misses go to FILL; a fault or the last word ends the fill.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (i_req && !w_bad && !w_hit) w_state_nxt = c_FILL;
            c_FILL:  if (nor_resp && (nor_fault || w_last)) w_state_nxt = c_RESP;
            c_RESP:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Control datapath: line validity, fill sequencing and the registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_flush_pend <= 1'b0;
            r_fill_fault <= 1'b0;
            r_cnt        <= '0;
            r_tag        <= '0;
            r_addr       <= '0;
            r_acc        <= '0;
            i_resp       <= 1'b0;
            i_fault      <= 1'b0;
            i_rdata      <= '0;
            nor_req      <= 1'b0;
            nor_addr     <= '0;
        end else begin
            i_resp  <= 1'b0;
            nor_req <= 1'b0;
            // Outside FILL a flush kills the line at once; a same-cycle hit still sees the old valid.
            if (flush && r_state != c_FILL) r_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (i_req) begin
                        if (w_bad) begin
                            i_resp  <= 1'b1;
                            i_fault <= 1'b1;
                            i_rdata <= '0;
                        end else if (w_hit) begin
                            i_resp  <= 1'b1;
                            i_fault <= 1'b0;
                            i_rdata <= f_extract(r_line[i_addr[OFF_W-1:2]], i_addr[1:0], i_acc);
                        end else begin
                            r_addr       <= i_addr;
                            r_acc        <= i_acc;
                            r_valid      <= 1'b0;
                            r_cnt        <= '0;
                            r_flush_pend <= 1'b0;
                            r_fill_fault <= 1'b0;
                            nor_req      <= 1'b1;
                            nor_addr     <= {i_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                c_FILL: begin
                    if (flush) r_flush_pend <= 1'b1;
                    if (nor_resp) begin
                        if (nor_fault) begin
                            r_fill_fault <= 1'b1;
                            r_flush_pend <= 1'b0;
                        end else if (w_last) begin
                            r_valid      <= !r_flush_pend && !flush;
                            r_tag        <= r_addr[XLEN-1:OFF_W];
                            r_flush_pend <= 1'b0;
                        end else begin
                            r_cnt    <= w_cnt_inc;
                            nor_req  <= 1'b1;
                            nor_addr <= {r_addr[XLEN-1:OFF_W], w_cnt_inc, 2'b00};
                        end
                    end
                end
                c_RESP: begin
                    i_resp  <= 1'b1;
                    i_fault <= r_fill_fault;
                    i_rdata <= r_fill_fault ? '0
                             : f_extract(r_line[r_addr[OFF_W-1:2]], r_addr[1:0], r_acc);
                end
                default: ;
            endcase
        end
    end

    // Line storage: capture each good fill word at its slot.
    always_ff @(posedge clk) begin
        if (r_state == c_FILL && nor_resp && !nor_fault) r_line[r_cnt] <= nor_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_nor_fetch_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_nor_fetch_buffer
// Description : Scoreboard bench for nor_fetch_buffer with a NOR responder
//               that answers in the third cycle of each request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nor_fetch_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] i_addr;
    logic        i_w_rb;
    logic [1:0]  i_acc;
    logic [31:0] i_wdata;
    logic        i_req;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        i_fault;
    logic [31:0] nor_addr;
    logic        nor_w_rb;
    logic [1:0]  nor_acc;
    logic [31:0] nor_wdata;
    logic        nor_req;
    logic [31:0] nor_rdata;
    logic        nor_resp;
    logic        nor_fault;

    nor_fetch_buffer #(.LINE_WORDS(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .i_addr    (i_addr),
        .i_w_rb    (i_w_rb),
        .i_acc     (i_acc),
        .i_wdata   (i_wdata),
        .i_req     (i_req),
        .i_rdata   (i_rdata),
        .i_resp    (i_resp),
        .i_fault   (i_fault),
        .nor_addr  (nor_addr),
        .nor_w_rb  (nor_w_rb),
        .nor_acc   (nor_acc),
        .nor_wdata (nor_wdata),
        .nor_req   (nor_req),
        .nor_rdata (nor_rdata),
        .nor_resp  (nor_resp),
        .nor_fault (nor_fault)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        fault;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] fault_addr;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    // Reference extraction written as explicit slice selection.
    function automatic logic [31:0] exp_extract(input logic [31:0] w, input logic [31:0] a, input logic [1:0] acc);
        logic [31:0] r;
        r = 32'h0;
        if (acc == 2'd0) begin
            case (a[1:0])
                2'd0: r = {24'h0, w[7:0]};
                2'd1: r = {24'h0, w[15:8]};
                2'd2: r = {24'h0, w[23:16]};
                default: r = {24'h0, w[31:24]};
            endcase
        end else if (acc == 2'd1) begin
            r = a[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
        end else if (acc == 2'd2) begin
            r = w;
        end
        return r;
    endfunction

    // NOR responder: records each request, checks its address, answers two cycles later.
    initial begin : g_responder
        int          pend;
        logic [31:0] pend_addr;
        pend      = 0;
        pend_addr = 32'h0;
        nor_resp  = 1'b0;
        nor_fault = 1'b0;
        nor_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            nor_resp  = 1'b0;
            nor_fault = 1'b0;
            nor_rdata = 32'h0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    nor_resp  = 1'b1;
                    nor_fault = (pend_addr == fault_addr);
                    nor_rdata = nor_fault ? 32'hDEAD_BEEF : mem_rd(pend_addr);
                end
            end
            if (nor_req === 1'b1) begin
                if (addr_q.size() == 0) chk("spurious_nor_req", nor_addr, 32'hFFFF_FFFF);
                else chk("nor_addr", nor_addr, addr_q.pop_front());
                pend      = 2;
                pend_addr = nor_addr;
            end
        end
    end

    // Response monitor: pops the scoreboard on every i_resp.
    initial begin : g_monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (i_resp === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_i_resp", 32'(i_resp), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "/rdata"}, i_rdata, e.data);
                    chk({e.name, "/fault"}, 32'(i_fault), 32'(e.fault));
                    chk({e.name, "/latency"}, 32'(cyc - e.t0), 32'(e.lat));
                end
            end
        end
    end

    task automatic push_fill(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) addr_q.push_back(base + 32'(4 * k));
    endtask

    task automatic issue_req(input string name, input logic [31:0] a, input logic w, input logic [1:0] acc,
                             input logic fl, input logic [31:0] d, input logic f, input int lat);
        i_addr  = a;
        i_w_rb  = w;
        i_acc   = acc;
        i_wdata = 32'hFFFF_FFFF;
        i_req   = 1'b1;
        flush   = fl;
        exp_q.push_back('{name, d, f, lat, cyc});
        @(posedge clk); #2;
        i_req = 1'b0;
        flush = 1'b0;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        if (exp_q.size() != 0) begin
            chk("resp_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
        chk("missing_nor_req", 32'(addr_q.size()), 32'h0);
        addr_q.delete();
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [1:0] acc, input int fill_words);
        logic [31:0] d;
        d = exp_extract(mem_rd({a[31:2], 2'b00}), a, acc);
        push_fill({a[31:4], 4'h0}, fill_words);
        issue_req(name, a, 1'b0, acc, 1'b0, d, 1'b0, (fill_words == 0) ? 1 : 2 + 3 * fill_words);
        wait_resp();
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
    endtask

    initial begin : g_main
        bit seen;
        rst        = 1'b1;
        flush      = 1'b0;
        i_req      = 1'b0;
        i_addr     = 32'h0;
        i_w_rb     = 1'b0;
        i_acc      = 2'd2;
        i_wdata    = 32'h0;
        fault_addr = 32'h1;
        mem[32'h100] = 32'h11;
        mem[32'h104] = 32'h22;
        mem[32'h108] = 32'h33;
        mem[32'h10C] = 32'h44;
        repeat (3) @(posedge clk);
        #2;
        chk("reset/i_resp",    32'(i_resp),    32'h0);
        chk("reset/i_fault",   32'(i_fault),   32'h0);
        chk("reset/nor_req",   32'(nor_req),   32'h0);
        chk("reset/i_rdata",   i_rdata,        32'h0);
        chk("reset/nor_addr",  nor_addr,       32'h0);
        chk("reset/nor_w_rb",  32'(nor_w_rb),  32'h0);
        chk("reset/nor_acc",   32'(nor_acc),   32'h2);
        chk("reset/nor_wdata", nor_wdata,      32'h0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Cold miss: four-word fill, answer 14 cycles after the request.
        rd("miss_0x100", 32'h100, 2'd2, 4);

        // New contents at 0x108, then byte/half hits out of the refilled line.
        mem[32'h108] = 32'h3322_1100;
        pulse_flush();
        rd("refill_0x108", 32'h108, 2'd2, 4);
        rd("hit_byte_0x109", 32'h109, 2'd0, 0);
        rd("hit_byte_0x10A", 32'h10A, 2'd0, 0);
        rd("hit_half_0x10A", 32'h10A, 2'd1, 0);
        rd("hit_byte_0x10F", 32'h10F, 2'd0, 0);

        // Writes and misaligned reads fault immediately with no NOR traffic.
        issue_req("write_0x100", 32'h100, 1'b1, 2'd2, 1'b0, 32'h0, 1'b1, 1);
        wait_resp();
        issue_req("half_0x101", 32'h101, 1'b0, 2'd1, 1'b0, 32'h0, 1'b1, 1);
        wait_resp();
        issue_req("word_0x102", 32'h102, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 1);
        wait_resp();

        // Downstream fault on the second word aborts the fill; the re-read refills.
        pulse_flush();
        fault_addr = 32'h104;
        push_fill(32'h100, 2);
        issue_req("fault_fill", 32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 8);
        wait_resp();
        fault_addr = 32'h1;
        rd("after_fault_0x100", 32'h100, 2'd2, 4);

        // Flush in the middle of a fill: data still returned, line left invalid.
        push_fill(32'h200, 4);
        issue_req("flush_in_fill", 32'h200, 1'b0, 2'd2, 1'b0, mem_rd(32'h200), 1'b0, 14);
        repeat (2) @(posedge clk);
        #2;
        pulse_flush();
        wait_resp();
        rd("after_fill_flush", 32'h204, 2'd2, 4);

        // Flush with a same-cycle request hits on the old line, then the line is gone.
        issue_req("hit_with_flush", 32'h208, 1'b0, 2'd2, 1'b1, mem_rd(32'h208), 1'b0, 1);
        wait_resp();
        rd("miss_after_flush", 32'h20C, 2'd2, 4);

        // Top-of-space line: fill addresses stay inside the line.
        rd("top_half", 32'hFFFF_FFFE, 2'd1, 4);
        rd("top_byte_hit", 32'hFFFF_FFF1, 2'd0, 0);

        // Reset during a fill; the outstanding NOR answer arrives as a stray response.
        push_fill(32'h300, 1);
        issue_req("aborted", 32'h300, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 14);
        seen = (nor_req === 1'b1);
        for (int i = 0; i < 5 && !seen; i++) begin
            @(posedge clk); #2;
            seen = (nor_req === 1'b1);
        end
        chk("abort/nor_req_seen", 32'(seen), 32'h1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.delete();
        repeat (6) @(posedge clk);
        #2;
        chk("abort/i_resp", 32'(i_resp), 32'h0);
        chk("abort/nor_req_left", 32'(addr_q.size()), 32'h0);
        addr_q.delete();
        rd("post_rst_0x208", 32'h208, 2'd2, 4);
        rd("post_rst_0x300", 32'h304, 2'd2, 4);
        rd("post_rst_hit", 32'h30C, 2'd1, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
